// File: rtl/ldtu_lane_scheduler.sv
// Output-lane scheduler for the LiTE-DTU: picks SYNC / CALIB / TEST / DATA once per
// word slot, loads the four serializer lanes and raises handshake / dtu_ack.
module ldtu_lane_scheduler #(
  parameter int                  Nbits_32  = 32,
  parameter int                  WORD_CYC  = 4,
  parameter int                  SYNC_LEN  = 16,
  parameter logic [Nbits_32-1:0] SYNC_WORD = 32'hACCCCCCC,
  parameter logic [Nbits_32-1:0] IDLE_WORD = 32'hEAAAAAAA
) (
  input  logic                clock,
  input  logic                rst_b,
  input  logic                test_enable,
  input  logic                calibration_busy_1,
  input  logic                calibration_busy_10,
  input  logic                sync_req,
  input  logic                dtu_valid,
  input  logic [Nbits_32-1:0] dtu_in_0,
  input  logic [Nbits_32-1:0] dtu_in_1,
  input  logic [Nbits_32-1:0] dtu_in_2,
  input  logic [Nbits_32-1:0] dtu_in_3,
  input  logic [Nbits_32-1:0] atu_in_0,
  input  logic [Nbits_32-1:0] atu_in_1,
  input  logic [Nbits_32-1:0] atu_in_2,
  input  logic [Nbits_32-1:0] atu_in_3,
  output logic [Nbits_32-1:0] data_out_0,
  output logic [Nbits_32-1:0] data_out_1,
  output logic [Nbits_32-1:0] data_out_2,
  output logic [Nbits_32-1:0] data_out_3,
  output logic                handshake,
  output logic                dtu_ack,
  output logic [1:0]          mode,
  output logic                underflow
);

  localparam int              CNT_W      = (WORD_CYC > 1) ? $clog2(WORD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WORD_CYC - 1);
  localparam logic [7:0]      SYNC_LEN_8 = 8'(SYNC_LEN);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_CALIB = 2'd1,
    ST_TEST  = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  logic [CNT_W-1:0]    r_cnt;
  state_t              r_state;
  logic [7:0]          r_sync_cnt;
  logic                r_pending;
  logic [Nbits_32-1:0] r_lane [4];
  logic                r_handshake;
  logic                r_dtu_ack;
  logic                r_underflow;

  logic                w_bnd;
  logic                w_sync_take;
  state_t              w_next;
  logic [Nbits_32-1:0] w_dtu  [4];
  logic [Nbits_32-1:0] w_atu  [4];
  logic [Nbits_32-1:0] w_lane [4];
  logic                w_ack;
  logic                w_uf;

  assign w_dtu[0] = dtu_in_0;
  assign w_dtu[1] = dtu_in_1;
  assign w_dtu[2] = dtu_in_2;
  assign w_dtu[3] = dtu_in_3;
  assign w_atu[0] = atu_in_0;
  assign w_atu[1] = atu_in_1;
  assign w_atu[2] = atu_in_2;
  assign w_atu[3] = atu_in_3;

  assign w_bnd = (r_cnt == CNT_LAST);
  // A request on the boundary edge itself is honoured without passing through r_pending.
  assign w_sync_take = r_pending | sync_req;

  always_comb begin
    w_next = ST_DATA;
    if (w_sync_take) begin
      w_next = ST_SYNC;
    end else if ((r_state == ST_SYNC) && (r_sync_cnt < SYNC_LEN_8)) begin
      w_next = ST_SYNC;
    end else if (calibration_busy_1 | calibration_busy_10) begin
      w_next = ST_CALIB;
    end else if (test_enable) begin
      w_next = ST_TEST;
    end
  end

  always_comb begin
    w_ack = 1'b0;
    w_uf  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_lane[k] = IDLE_WORD;
    end
    case (w_next)
      ST_SYNC: begin
        for (int k = 0; k < 4; k++) w_lane[k] = SYNC_WORD;
      end
      ST_TEST: begin
        for (int k = 0; k < 4; k++) w_lane[k] = w_atu[k];
      end
      ST_DATA: begin
        if (dtu_valid) begin
          for (int k = 0; k < 4; k++) w_lane[k] = w_dtu[k];
          w_ack = 1'b1;
        end else begin
          w_uf = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt       <= '0;
      r_state     <= ST_SYNC;
      r_sync_cnt  <= '0;
      r_pending   <= 1'b0;
      r_handshake <= 1'b0;
      r_dtu_ack   <= 1'b0;
      r_underflow <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_lane[k] <= '0;
      end
    end else begin
      r_handshake <= w_bnd;
      r_dtu_ack   <= w_bnd & w_ack;
      if (w_bnd) begin
        r_cnt     <= '0;
        r_pending <= 1'b0;
        r_state   <= w_next;
        // A (re)started burst counts the boundary that enters it as slot 1.
        if (w_sync_take) begin
          r_sync_cnt <= 8'd1;
        end else if (w_next == ST_SYNC) begin
          r_sync_cnt <= r_sync_cnt + 8'd1;
        end else begin
          r_sync_cnt <= '0;
        end
        for (int k = 0; k < 4; k++) begin
          r_lane[k] <= w_lane[k];
        end
        if (w_uf) begin
          r_underflow <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (sync_req) begin
          r_pending <= 1'b1;
        end
      end
    end
  end

  assign data_out_0 = r_lane[0];
  assign data_out_1 = r_lane[1];
  assign data_out_2 = r_lane[2];
  assign data_out_3 = r_lane[3];
  assign handshake  = r_handshake;
  assign dtu_ack    = r_dtu_ack;
  assign mode       = r_state;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_ldtu_lane_scheduler.sv
// Directed, table-driven bench for ldtu_lane_scheduler (WORD_CYC=4, SYNC_LEN=16).
module tb_ldtu_lane_scheduler;

  localparam int          WC     = 4;
  localparam int          SL     = 16;
  localparam logic [31:0] SYNC_W = 32'hACCCCCCC;
  localparam logic [31:0] IDLE_W = 32'hEAAAAAAA;
  localparam logic [31:0] ATU_B  = 32'h5A5A0000;

  logic        clock = 1'b0;
  logic        rst_b;
  logic        test_enable, calibration_busy_1, calibration_busy_10, sync_req, dtu_valid;
  logic [31:0] dtu_in_0, dtu_in_1, dtu_in_2, dtu_in_3;
  logic [31:0] atu_in_0, atu_in_1, atu_in_2, atu_in_3;
  logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic        handshake, dtu_ack, underflow;
  logic [1:0]  mode;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  ldtu_lane_scheduler #(
    .Nbits_32 (32),
    .WORD_CYC (WC),
    .SYNC_LEN (SL),
    .SYNC_WORD(SYNC_W),
    .IDLE_WORD(IDLE_W)
  ) dut (
    .clock              (clock),
    .rst_b              (rst_b),
    .test_enable        (test_enable),
    .calibration_busy_1 (calibration_busy_1),
    .calibration_busy_10(calibration_busy_10),
    .sync_req           (sync_req),
    .dtu_valid          (dtu_valid),
    .dtu_in_0           (dtu_in_0),
    .dtu_in_1           (dtu_in_1),
    .dtu_in_2           (dtu_in_2),
    .dtu_in_3           (dtu_in_3),
    .atu_in_0           (atu_in_0),
    .atu_in_1           (atu_in_1),
    .atu_in_2           (atu_in_2),
    .atu_in_3           (atu_in_3),
    .data_out_0         (data_out_0),
    .data_out_1         (data_out_1),
    .data_out_2         (data_out_2),
    .data_out_3         (data_out_3),
    .handshake          (handshake),
    .dtu_ack            (dtu_ack),
    .mode               (mode),
    .underflow          (underflow)
  );

  // One record per word slot: inputs present at the boundary edge, outputs expected after it.
  typedef struct packed {
    logic        valid;
    logic [31:0] d0;
    logic        tst;
    logic        cal1;
    logic        cal10;
    logic        sreq;
    logic        smid;
    logic [1:0]  e_mode;
    logic [31:0] e_o0;
    logic [31:0] e_o3;
    logic        e_ack;
    logic        e_uf;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(input logic valid, input logic [31:0] d0, input logic tst,
                              input logic cal1, input logic cal10, input logic sreq,
                              input logic smid, input logic [1:0] e_mode,
                              input logic [31:0] e_o0, input logic [31:0] e_o3,
                              input logic e_ack, input logic e_uf);
    vec_t v;
    v.valid = valid;  v.d0 = d0;     v.tst = tst;     v.cal1 = cal1;
    v.cal10 = cal10;  v.sreq = sreq; v.smid = smid;   v.e_mode = e_mode;
    v.e_o0 = e_o0;    v.e_o3 = e_o3; v.e_ack = e_ack; v.e_uf = e_uf;
    return v;
  endfunction

  function automatic vec_t v_sync(input logic [31:0] d0, input logic uf, input logic smid);
    return mk(1'b1, d0, 1'b0, 1'b0, 1'b0, 1'b0, smid, 2'd0, SYNC_W, SYNC_W, 1'b0, uf);
  endfunction

  function automatic vec_t v_data(input logic [31:0] d0, input logic uf);
    return mk(1'b1, d0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, d0, d0 + 32'd3, 1'b1, uf);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".out0"}, data_out_0, 32'd0);
    chk({tag, ".out1"}, data_out_1, 32'd0);
    chk({tag, ".out2"}, data_out_2, 32'd0);
    chk({tag, ".out3"}, data_out_3, 32'd0);
    chk({tag, ".hs"},   {31'd0, handshake}, 32'd0);
    chk({tag, ".ack"},  {31'd0, dtu_ack}, 32'd0);
    chk({tag, ".mode"}, {30'd0, mode}, 32'd0);
    chk({tag, ".uf"},   {31'd0, underflow}, 32'd0);
  endtask

  // Inputs are scrambled between boundaries so only the boundary-edge values may matter.
  task automatic do_slot(input vec_t v, input string tag);
    for (int c = 1; c < WC; c++) begin
      tick();
      chk({tag, ".hs_mid"},  {31'd0, handshake}, 32'd0);
      chk({tag, ".ack_mid"}, {31'd0, dtu_ack}, 32'd0);
      if (c == 1) begin
        dtu_valid           = ~v.valid;
        test_enable         = ~v.tst;
        calibration_busy_1  = ~v.cal1;
        calibration_busy_10 = ~v.cal10;
        dtu_in_0 = 32'hDEADBEEF; dtu_in_1 = 32'hDEADBEEF;
        dtu_in_2 = 32'hDEADBEEF; dtu_in_3 = 32'hDEADBEEF;
        atu_in_0 = 32'h0BAD0BAD; atu_in_1 = 32'h0BAD0BAD;
        atu_in_2 = 32'h0BAD0BAD; atu_in_3 = 32'h0BAD0BAD;
        sync_req = v.smid;
      end else if (c == 2) begin
        sync_req = 1'b0;
      end
      if (c == WC - 1) begin
        dtu_valid           = v.valid;
        test_enable         = v.tst;
        calibration_busy_1  = v.cal1;
        calibration_busy_10 = v.cal10;
        dtu_in_0 = v.d0;         dtu_in_1 = v.d0 + 32'd1;
        dtu_in_2 = v.d0 + 32'd2; dtu_in_3 = v.d0 + 32'd3;
        atu_in_0 = ATU_B;         atu_in_1 = ATU_B + 32'd1;
        atu_in_2 = ATU_B + 32'd2; atu_in_3 = ATU_B + 32'd3;
        sync_req = v.sreq;
      end
    end
    tick();
    sync_req = 1'b0;
    chk({tag, ".hs"},   {31'd0, handshake}, 32'd1);
    chk({tag, ".mode"}, {30'd0, mode}, {30'd0, v.e_mode});
    chk({tag, ".out0"}, data_out_0, v.e_o0);
    chk({tag, ".out3"}, data_out_3, v.e_o3);
    chk({tag, ".ack"},  {31'd0, dtu_ack}, {31'd0, v.e_ack});
    chk({tag, ".uf"},   {31'd0, underflow}, {31'd0, v.e_uf});
  endtask

  initial begin
    rst_b = 1'b0;
    test_enable = 1'b0; calibration_busy_1 = 1'b0; calibration_busy_10 = 1'b0;
    sync_req = 1'b0; dtu_valid = 1'b0;
    dtu_in_0 = '0; dtu_in_1 = '0; dtu_in_2 = '0; dtu_in_3 = '0;
    atu_in_0 = '0; atu_in_1 = '0; atu_in_2 = '0; atu_in_3 = '0;

    tbl[0] = v_data(32'd100, 1'b0);
    tbl[1] = v_data(32'd101, 1'b0);
    tbl[2] = v_data(32'd102, 1'b0);
    tbl[3] = mk(1'b0, 32'd200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, IDLE_W, IDLE_W, 1'b0, 1'b1);
    tbl[4] = v_data(32'd103, 1'b1);
    tbl[5] = mk(1'b1, 32'd104, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, IDLE_W, IDLE_W, 1'b0, 1'b1);
    tbl[6] = mk(1'b1, 32'd105, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, IDLE_W, IDLE_W, 1'b0, 1'b1);
    tbl[7] = mk(1'b1, 32'd106, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, ATU_B, ATU_B + 32'd3, 1'b0, 1'b1);
    tbl[8] = mk(1'b0, 32'd107, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, ATU_B, ATU_B + 32'd3, 1'b0, 1'b1);
    tbl[9] = mk(1'b1, 32'd108, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, SYNC_W, SYNC_W, 1'b0, 1'b1);
    for (int i = 10; i < 25; i++) tbl[i] = v_sync(32'd200 + 32'(i), 1'b1, 1'b0);
    tbl[25] = v_data(32'd300, 1'b1);

    tick();
    tick();
    chk_reset("rst");
    rst_b = 1'b1;

    for (int i = 0; i < SL; i++) do_slot(v_sync(32'h10000000, 1'b0, 1'b0), $sformatf("burst%0d", i));
    do_slot(v_data(32'h10000000, 1'b0), "first_data");

    for (int i = 0; i < 26; i++) do_slot(tbl[i], $sformatf("vec%0d", i));

    // Mid-slot request from DATA, then a restart during burst slot 10.
    do_slot(v_sync(32'd400, 1'b1, 1'b1), "sreq_mid");
    for (int i = 2; i <= 10; i++) do_slot(v_sync(32'd400, 1'b1, 1'b0), $sformatf("rs_slot%0d", i));
    do_slot(v_sync(32'd400, 1'b1, 1'b1), "restart");
    for (int i = 2; i <= SL; i++) do_slot(v_sync(32'd400, 1'b1, 1'b0), $sformatf("rs_burst%0d", i));
    do_slot(v_data(32'h4000, 1'b1), "rs_data");

    // Asynchronous reset mid-slot while in DATA.
    tick();
    tick();
    rst_b = 1'b0;
    #1;
    chk_reset("midrst");
    @(posedge clock);
    #1;
    rst_b = 1'b1;
    for (int i = 0; i < SL; i++) do_slot(v_sync(32'h7000, 1'b0, 1'b0), $sformatf("mr_burst%0d", i));
    do_slot(v_data(32'h7000, 1'b0), "mr_data");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ldtu_lane_scheduler.md
# ldtu_lane_scheduler

Output-lane scheduler between the LiTE-DTU datapath, the ADC test unit and the four 32-bit serializer lanes. It owns the word-boundary timing. It decides, once per word slot, whether the four lanes carry a sync pattern, idle words, ADC test-unit data or normal DTU data. It then loads the selected words and issues the serializer handshake. It also acknowledges consumed DTU words back to the datapath.

## Interface
Parameters:
- Nbits_32, 32, lane word width
- WORD_CYC, 4, clock cycles per word slot (32 bits at 1.28 Gb/s vs 160 MHz); legal range 2..16
- SYNC_LEN, 16, word slots in one sync burst; legal range 1..255
- SYNC_WORD, 32'hACCCCCCC, pattern sent on all lanes in SYNC
- IDLE_WORD, 32'hEAAAAAAA, pattern sent in CALIB and on DTU underflow

Ports:
- clock  in  1  system clock (160 MHz)
- rst_b  in  1  asynchronous, active-low reset
- test_enable  in  1  level; select ADC test-unit data
- calibration_busy_1  in  1  level; gain-1 ADC calibrating
- calibration_busy_10  in  1  level; gain-10 ADC calibrating
- sync_req  in  1  one-cycle pulse; request a sync burst
- dtu_valid  in  1  DTU words on dtu_in_0..3 are valid
- dtu_in_0..dtu_in_3  in  32 each  DTU lane words
- atu_in_0..atu_in_3  in  32 each  ADC test-unit lane words
- data_out_0..data_out_3  out  32 each  registered words to serializers
- handshake  out  1  one-cycle pulse; new words on data_out_*
- dtu_ack  out  1  one-cycle pulse; DTU words consumed
- mode  out  2  current state: 0 SYNC, 1 CALIB, 2 TEST, 3 DATA
- underflow  out  1  sticky; DATA slot found dtu_valid low; cleared only by reset

## Operation
- **Slot counter** `cnt` runs 0..WORD_CYC-1 and wraps. The edge at which `cnt==WORD_CYC-1` is the slot boundary. All state changes and lane loads happen only at slot boundaries.
- **State machine:** SYNC, CALIB, TEST, DATA.
- **Next-state priority at each boundary** (highest first):
  1. Pending sync request → SYNC, with `sync_cnt` cleared.
  2. In SYNC with `sync_cnt` < SYNC_LEN → stay in SYNC.
  3. `calibration_busy_1 | calibration_busy_10` → CALIB.
  4. `test_enable` → TEST.
  5. Otherwise → DATA.
- **sync_req** sets a pending flag on any cycle. The flag is cleared at the next boundary, which consumes it. A sync_req arriving during a SYNC burst restarts the burst from count 0.
- **sync_cnt** (8 bits) increments on each boundary whose next state is SYNC. A restarted burst counts that boundary as slot 1. The burst is exactly SYNC_LEN slots.
- **Lane load at each boundary**, selected by the *next* state:
  - SYNC: SYNC_WORD on all lanes.
  - CALIB: IDLE_WORD on all lanes.
  - TEST: atu_in_k to lane k.
  - DATA with dtu_valid=1: dtu_in_k to lane k.
  - DATA with dtu_valid=0: IDLE_WORD on all lanes, and underflow set.
- **dtu_ack** is pulsed only for slots loaded from dtu_in_*.
- All outputs are registered.

## Timing
- **Reset values:** cnt=0, state SYNC, sync_cnt=0, pending=0, data_out_*=0, handshake=0, dtu_ack=0, mode=0, underflow=0.
- **Reset is asynchronous** and takes effect mid-slot or mid-burst. After release the block always restarts a full SYNC burst.
- **First boundary** is the WORD_CYC-th rising edge after rst_b deasserts. handshake is high for exactly the cycle following that edge, then once every WORD_CYC cycles.
- **Load latency:** data_out_*, mode and dtu_ack update on the boundary edge itself. handshake and dtu_ack are high in the same cycle; handshake is never high on consecutive cycles.
- **Input sampling:** dtu_in_*, atu_in_*, dtu_valid, test_enable and calibration_busy_* are sampled only on the boundary edge. Changes between boundaries have no effect.
- **sync_req timing:** a sync_req on the boundary edge itself is taken at that boundary. A sync_req one cycle after the boundary waits a full slot.
- **Simultaneous inputs:** with calibration_busy and test_enable both high, the state is CALIB.
- **Mode switching:** mode never changes more than once per slot.

## Test plan
- **Reset → sync:** release rst_b with WORD_CYC=4, SYNC_LEN=16. Required: first handshake in cycle 5; 16 handshakes carrying 32'hACCCCCCC; the 17th carries DTU data with mode=3; no dtu_ack before it.
- **Data flow:** dtu_valid=1 with an incrementing dtu_in_0. Required: each handshake carries the value sampled at its boundary; dtu_ack is coincident with handshake; dtu_ack count equals slot count.
- **Underflow:** drop dtu_valid for one boundary. Required: that slot carries 32'hEAAAAAAA on all lanes; no dtu_ack; underflow=1 and stays 1 after dtu_valid returns.
- **Priority:** raise calibration_busy_10 and test_enable together mid-slot. Required: mode=1 and IDLE_WORD from the next boundary. Drop calibration_busy_10: required mode=2 with atu_in_* on the lanes.
- **Sync restart:** pulse sync_req during burst slot 10. Required: the burst restarts at the next boundary, giving 16 further SYNC slots. Also pulse sync_req exactly on a boundary edge: required SYNC at that boundary.
- **Mid-operation reset:** assert rst_b low for 1 cycle mid-slot while in DATA. Required: all outputs are 0 immediately; a full 16-slot SYNC burst follows release.
